// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception-type encodings from the
// exception stage, ExcCode values and Status/Cause bit positions.
package cp0_pkg;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_TYPE_INT  = 5'b00000,
        EXC_TYPE_ADDR = 5'b00001,
        EXC_TYPE_OVF  = 5'b00010,
        EXC_TYPE_SYS  = 5'b00011,
        EXC_TYPE_BP   = 5'b00100,
        EXC_TYPE_ERET = 5'b00101,
        EXC_TYPE_RI   = 5'b10101
    } exc_type_e;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0A;
    localparam logic [4:0] EXCCODE_OV   = 5'h0C;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_LO   = 8;
    localparam int STATUS_IM_HI   = 15;
    localparam int STATUS_BEV_BIT = 22;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_TI_BIT = 30;
    localparam int CAUSE_BD_BIT = 31;

    // True for the exception types that enter the handler (everything but eret
    // and unknown codes).
    function automatic logic is_fault_type(input logic [4:0] etype);
        logic hit;
        hit = 1'b0;
        case (etype)
            EXC_TYPE_INT, EXC_TYPE_ADDR, EXC_TYPE_OVF, EXC_TYPE_SYS,
            EXC_TYPE_BP, EXC_TYPE_RI: hit = 1'b1;
            default:                  hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [4:0] exc_code_of(input logic [4:0] etype, input logic is_store);
        logic [4:0] code;
        code = EXCCODE_INT;
        case (etype)
            EXC_TYPE_ADDR: code = is_store ? EXCCODE_ADES : EXCCODE_ADEL;
            EXC_TYPE_OVF:  code = EXCCODE_OV;
            EXC_TYPE_SYS:  code = EXCCODE_SYS;
            EXC_TYPE_BP:   code = EXCCODE_BP;
            EXC_TYPE_RI:   code = EXCCODE_RI;
            default:       code = EXCCODE_INT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on a
// Count==Compare match caused by a Count update and clears on a Compare write.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic        tick_reg;
    logic [31:0] count_reg, count_next;
    logic [31:0] compare_reg, compare_next;
    logic        ti_reg, ti_next;
    logic        count_upd;

    always_comb begin
        count_next   = count_reg;
        count_upd    = 1'b0;
        compare_next = compare_reg;
        ti_next      = ti_reg;

        // A software reload takes the place of this cycle's increment.
        if (count_we) begin
            count_next = wdata;
            count_upd  = 1'b1;
        end else if (tick_reg) begin
            count_next = count_reg + 32'd1;
            count_upd  = 1'b1;
        end

        if (count_upd && (count_next == compare_reg)) begin
            ti_next = 1'b1;
        end

        if (compare_we) begin
            compare_next = wdata;
            ti_next      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_reg    <= 1'b0;
            count_reg   <= '0;
            compare_reg <= '0;
            ti_reg      <= 1'b0;
        end else begin
            tick_reg    <= ~tick_reg;
            count_reg   <= count_next;
            compare_reg <= compare_next;
            ti_reg      <= ti_next;
        end
    end

    assign count_o   = count_reg;
    assign compare_o = compare_reg;
    assign ti_o      = ti_reg;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: commits exceptions from MEM, serves MFC0/MTC0 and
// raises the interrupt request. The Count/Compare timer exists only with CP0_TIMER_EN.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic BEV_RESET = 1'b1
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic        exception_i,
    input  logic [4:0]  exception_type_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] badvaddr_i,
    input  logic        mem_we_i,
    output logic [31:0] epc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic        int_req_o,
    output logic        timer_int_o
);

    logic [31:0] badvaddr_reg, badvaddr_next;
    logic [31:0] epc_reg, epc_next;
    logic [7:0]  status_im_reg, status_im_next;
    logic        status_exl_reg, status_exl_next;
    logic        status_ie_reg, status_ie_next;
    logic        cause_bd_reg, cause_bd_next;
    logic [4:0]  cause_exc_reg, cause_exc_next;
    logic [1:0]  cause_ip_sw_reg, cause_ip_sw_next;
    logic [5:0]  cause_ip_hw_reg;

    logic        is_fault;
    logic        is_eret;
    logic        mtc0_en;
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic        ti;

    // An exception commit in the same cycle swallows any MTC0.
    assign is_fault = exception_i && is_fault_type(exception_type_i);
    assign is_eret  = exception_i && (exception_type_i == EXC_TYPE_ERET);
    assign mtc0_en  = we_i && !exception_i;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (mtc0_en && (waddr_i == CP0_REG_COUNT)),
        .compare_we (mtc0_en && (waddr_i == CP0_REG_COMPARE)),
        .wdata      (wdata_i),
        .count_o    (count_val),
        .compare_o  (compare_val),
        .ti_o       (ti)
    );
`else
    assign count_val   = '0;
    assign compare_val = '0;
    assign ti          = 1'b0;
`endif

    always_comb begin
        badvaddr_next    = badvaddr_reg;
        epc_next         = epc_reg;
        status_im_next   = status_im_reg;
        status_exl_next  = status_exl_reg;
        status_ie_next   = status_ie_reg;
        cause_bd_next    = cause_bd_reg;
        cause_exc_next   = cause_exc_reg;
        cause_ip_sw_next = cause_ip_sw_reg;

        if (is_fault) begin
            cause_exc_next  = exc_code_of(exception_type_i, mem_we_i);
            status_exl_next = 1'b1;
            // Nested exceptions keep the outermost return address.
            if (!status_exl_reg) begin
                epc_next      = is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                cause_bd_next = is_in_delayslot_i;
            end
            if (exception_type_i == EXC_TYPE_ADDR) begin
                badvaddr_next = badvaddr_i;
            end
        end else if (is_eret) begin
            status_exl_next = 1'b0;
        end else if (mtc0_en) begin
            case (waddr_i)
                CP0_REG_STATUS: begin
                    status_im_next  = wdata_i[STATUS_IM_HI:STATUS_IM_LO];
                    status_exl_next = wdata_i[STATUS_EXL_BIT];
                    status_ie_next  = wdata_i[STATUS_IE_BIT];
                end
                CP0_REG_CAUSE: cause_ip_sw_next = wdata_i[CAUSE_IP_LO+1:CAUSE_IP_LO];
                CP0_REG_EPC:   epc_next = wdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            badvaddr_reg    <= '0;
            epc_reg         <= '0;
            status_im_reg   <= '0;
            status_exl_reg  <= 1'b0;
            status_ie_reg   <= 1'b0;
            cause_bd_reg    <= 1'b0;
            cause_exc_reg   <= '0;
            cause_ip_sw_reg <= '0;
            cause_ip_hw_reg <= '0;
        end else begin
            badvaddr_reg    <= badvaddr_next;
            epc_reg         <= epc_next;
            status_im_reg   <= status_im_next;
            status_exl_reg  <= status_exl_next;
            status_ie_reg   <= status_ie_next;
            cause_bd_reg    <= cause_bd_next;
            cause_exc_reg   <= cause_exc_next;
            cause_ip_sw_reg <= cause_ip_sw_next;
            cause_ip_hw_reg <= int_i;
        end
    end

    always_comb begin
        status_o = '0;
        status_o[STATUS_BEV_BIT]             = BEV_RESET;
        status_o[STATUS_IM_HI:STATUS_IM_LO]  = status_im_reg;
        status_o[STATUS_EXL_BIT]             = status_exl_reg;
        status_o[STATUS_IE_BIT]              = status_ie_reg;

        // The timer shares IP7 with hardware line 5.
        cause_o = '0;
        cause_o[CAUSE_BD_BIT]                = cause_bd_reg;
        cause_o[CAUSE_TI_BIT]                = ti;
        cause_o[CAUSE_IP_HI]                 = cause_ip_hw_reg[5] | ti;
        cause_o[CAUSE_IP_HI-1:CAUSE_IP_LO+2] = cause_ip_hw_reg[4:0];
        cause_o[CAUSE_IP_LO+1:CAUSE_IP_LO]   = cause_ip_sw_reg;
        cause_o[CAUSE_EXC_HI:CAUSE_EXC_LO]   = cause_exc_reg;
    end

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            CP0_REG_BADVADDR: rdata_o = badvaddr_reg;
            CP0_REG_COUNT:    rdata_o = count_val;
            CP0_REG_COMPARE:  rdata_o = compare_val;
            CP0_REG_STATUS:   rdata_o = status_o;
            CP0_REG_CAUSE:    rdata_o = cause_o;
            CP0_REG_EPC:      rdata_o = epc_reg;
            default:          rdata_o = '0;
        endcase
    end

    assign epc_o       = epc_reg;
    assign int_req_o   = (|(cause_o[CAUSE_IP_HI:CAUSE_IP_LO] & status_im_reg))
                         & status_ie_reg & ~status_exl_reg;
    assign timer_int_o = ti;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: stimulus queues expected values, a negedge
// monitor pops and compares them against MFC0 data, int_req_o or timer_int_o.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        resetn;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic        exception_i;
    logic [4:0]  exception_type_i;
    logic        is_in_delayslot_i;
    logic [31:0] pc_i;
    logic [31:0] badvaddr_i;
    logic        mem_we_i;
    logic [31:0] epc_o, status_o, cause_o;
    logic        int_req_o;
    logic        timer_int_o;

`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    localparam int K_RDATA = 0;
    localparam int K_INTREQ = 1;
    localparam int K_TI = 2;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t        sb_q[$];
    chk_t        mon_c;
    logic [31:0] mon_act;
    logic        chk_req;
    logic        tb_tick;
    int          n_tests = 0;
    int          n_fail  = 0;

    cp0_regfile dut (
        .clk               (clk),
        .resetn            (resetn),
        .we_i              (we_i),
        .waddr_i           (waddr_i),
        .wdata_i           (wdata_i),
        .raddr_i           (raddr_i),
        .rdata_o           (rdata_o),
        .int_i             (int_i),
        .exception_i       (exception_i),
        .exception_type_i  (exception_type_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .pc_i              (pc_i),
        .badvaddr_i        (badvaddr_i),
        .mem_we_i          (mem_we_i),
        .epc_o             (epc_o),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .int_req_o         (int_req_o),
        .timer_int_o       (timer_int_o)
    );

    always #5 clk = ~clk;

    // Half-rate phase of the Count increment, tracked from reset.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) tb_tick <= 1'b0;
        else         tb_tick <= ~tb_tick;
    end

    always @(negedge clk) begin
        if (chk_req) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL scoreboard: check requested, got empty queue, required an entry");
            end else begin
                mon_c = sb_q.pop_front();
                case (mon_c.kind)
                    K_RDATA:  mon_act = rdata_o;
                    K_INTREQ: mon_act = {31'b0, int_req_o};
                    default:  mon_act = {31'b0, timer_int_o};
                endcase
                if (mon_act !== mon_c.exp) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got %08h, required %08h", mon_c.name, mon_act, mon_c.exp);
                end else begin
                    $display("[TB] ok   %s = %08h", mon_c.name, mon_act);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int kind, input logic [4:0] addr,
                              input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.exp  = exp;
        raddr_i = addr;
        sb_q.push_back(c);
        chk_req = 1'b1;
        step(1);
        chk_req = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        we_i    = 1'b1;
        waddr_i = addr;
        wdata_i = data;
        step(1);
        we_i    = 1'b0;
    endtask

    task automatic do_exc(input logic [4:0] etype, input logic [31:0] pc, input logic ds,
                          input logic [31:0] bva, input logic mwe);
        exception_i       = 1'b1;
        exception_type_i  = etype;
        pc_i              = pc;
        is_in_delayslot_i = ds;
        badvaddr_i        = bva;
        mem_we_i          = mwe;
        step(1);
        exception_i       = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
        int_i = '0; exception_i = 1'b0; exception_type_i = '0; is_in_delayslot_i = 1'b0;
        pc_i = '0; badvaddr_i = '0; mem_we_i = 1'b0; chk_req = 1'b0;
        step(3);
        resetn = 1'b1;

        // reset release
        expect_val("rst_status", K_RDATA, 5'd12, 32'h0040_0000);
        expect_val("rst_cause", K_RDATA, 5'd13, 32'h0000_0000);
        expect_val("rst_epc", K_RDATA, 5'd14, 32'h0000_0000);
        expect_val("rst_badvaddr", K_RDATA, 5'd8, 32'h0000_0000);
        expect_val("rst_int_req", K_INTREQ, 5'd0, 32'd0);
        expect_val("rst_timer_int", K_TI, 5'd0, 32'd0);

        // syscall in delay slot, nested overflow, eret
        do_exc(5'b00011, 32'hBFC0_0100, 1'b1, 32'h0, 1'b0);
        expect_val("sys_epc", K_RDATA, 5'd14, 32'hBFC0_00FC);
        expect_val("sys_cause", K_RDATA, 5'd13, 32'h8000_0020);
        expect_val("sys_status", K_RDATA, 5'd12, 32'h0040_0002);
        do_exc(5'b00010, 32'h1234_0000, 1'b0, 32'h0, 1'b0);
        expect_val("ovf_epc_held", K_RDATA, 5'd14, 32'hBFC0_00FC);
        expect_val("ovf_cause", K_RDATA, 5'd13, 32'h8000_0030);
        do_exc(5'b00101, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_val("eret_status", K_RDATA, 5'd12, 32'h0040_0000);
        expect_val("eret_cause", K_RDATA, 5'd13, 32'h8000_0030);

        // address errors: load then store
        do_exc(5'b00001, 32'h8000_0200, 1'b0, 32'h0000_1003, 1'b0);
        expect_val("adel_badvaddr", K_RDATA, 5'd8, 32'h0000_1003);
        expect_val("adel_cause", K_RDATA, 5'd13, 32'h0000_0010);
        expect_val("adel_epc", K_RDATA, 5'd14, 32'h8000_0200);
        do_exc(5'b00101, 32'h0, 1'b0, 32'h0, 1'b0);
        do_exc(5'b00001, 32'h8000_0300, 1'b1, 32'h0000_2006, 1'b1);
        expect_val("ades_badvaddr", K_RDATA, 5'd8, 32'h0000_2006);
        expect_val("ades_cause", K_RDATA, 5'd13, 32'h8000_0014);
        expect_val("ades_epc", K_RDATA, 5'd14, 32'h8000_02FC);
        do_exc(5'b00101, 32'h0, 1'b0, 32'h0, 1'b0);

        // MTC0 to EPC colliding with an interrupt commit
        we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'hDEAD_BEEF;
        do_exc(5'b00000, 32'h8000_0400, 1'b0, 32'h0, 1'b0);
        we_i = 1'b0;
        expect_val("collide_epc", K_RDATA, 5'd14, 32'h8000_0400);
        expect_val("collide_cause", K_RDATA, 5'd13, 32'h0000_0000);
        expect_val("collide_status", K_RDATA, 5'd12, 32'h0040_0002);
        do_exc(5'b00101, 32'h0, 1'b0, 32'h0, 1'b0);

        // plain MTC0 writes and write masks
        mtc0(5'd14, 32'h1234_5678);
        expect_val("mtc0_epc", K_RDATA, 5'd14, 32'h1234_5678);
        mtc0(5'd8, 32'hFFFF_FFFF);
        expect_val("badvaddr_ro", K_RDATA, 5'd8, 32'h0000_2006);
        expect_val("unmapped_rd", K_RDATA, 5'd15, 32'h0000_0000);
        mtc0(5'd13, 32'hFFFF_FFFF);
        expect_val("cause_mask", K_RDATA, 5'd13, 32'h0000_0300);
        mtc0(5'd13, 32'h0000_0000);
        mtc0(5'd12, 32'hFFFF_FFFF);
        expect_val("status_mask", K_RDATA, 5'd12, 32'h0040_FF03);
        expect_val("exl_masks_int", K_INTREQ, 5'd0, 32'd0);
        mtc0(5'd12, 32'h0000_0000);

        // timer: Count written on an increment cycle, so Count hits 5 ten edges later
        mtc0(5'd11, 32'h0000_0005);
        while (tb_tick !== 1'b1) step(1);
        mtc0(5'd9, 32'h0000_0000);
        step(9);
        expect_val("ti_before_match", K_TI, 5'd0, 32'd0);
        expect_val("ti_at_match", K_TI, 5'd0, TIMER ? 32'd1 : 32'd0);
        expect_val("count_at_match", K_RDATA, 5'd9, TIMER ? 32'd5 : 32'd0);
        mtc0(5'd12, 32'h0000_8001);
        expect_val("timer_int_req", K_INTREQ, 5'd0, TIMER ? 32'd1 : 32'd0);
        mtc0(5'd11, 32'h0000_1000);
        expect_val("compare_rd", K_RDATA, 5'd11, TIMER ? 32'h0000_1000 : 32'd0);
        expect_val("ti_cleared", K_TI, 5'd0, 32'd0);
        expect_val("int_req_cleared", K_INTREQ, 5'd0, 32'd0);

        // software interrupt gated by EXL
        mtc0(5'd12, 32'h0000_0101);
        mtc0(5'd13, 32'h0000_0100);
        expect_val("sw_cause", K_RDATA, 5'd13, 32'h0000_0100);
        expect_val("sw_int_req", K_INTREQ, 5'd0, 32'd1);
        do_exc(5'b00100, 32'h8000_0500, 1'b0, 32'h0, 1'b0);
        expect_val("bp_status", K_RDATA, 5'd12, 32'h0040_0103);
        expect_val("bp_cause", K_RDATA, 5'd13, 32'h0000_0124);
        expect_val("bp_exl_int_req", K_INTREQ, 5'd0, 32'd0);
        do_exc(5'b00101, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_val("eret_int_req", K_INTREQ, 5'd0, 32'd1);

        // hardware lines sampled into IP[15:10]
        int_i = 6'h21;
        step(1);
        expect_val("hw_ip_cause", K_RDATA, 5'd13, 32'h0000_8524);
        int_i = 6'h00;

        // asynchronous reset mid-cycle
        resetn = 1'b0;
        expect_val("async_rst_epc", K_RDATA, 5'd14, 32'h0000_0000);
        expect_val("async_rst_status", K_RDATA, 5'd12, 32'h0040_0000);
        resetn = 1'b1;
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
